// File: rtl/list_stream_pkg.sv
// Shared definitions for the pull-style list stream stages.
// Element width default, fill-width helper and end-of-list encoding.
package list_stream_pkg;

  localparam int unsigned LIST_WIDTH = 8;

  // value_valid level that marks the terminator on an ack
  localparam logic LIST_END = 1'b0;

  function automatic int unsigned fill_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/list_fifo.sv
// Element storage for list_prefetch: circular buffer with
// read/write pointers and an explicit occupancy count.
module list_fifo
  import list_stream_pkg::*;
#(
  parameter int unsigned WIDTH = LIST_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      ready,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic [fill_w(DEPTH)-1:0]  fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = fill_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;

  // pointers wrap through natural AW-bit overflow
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    fill_d   = fill_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clock or negedge ready) begin
    if (!ready) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign head = mem_q[rd_ptr_q];
  assign fill = fill_q;

endmodule

// File: rtl/list_prefetch.sv
// Read-ahead buffer for the list stream: prefetches upstream
// elements and answers consumer requests with 1-cycle latency.
module list_prefetch
  import list_stream_pkg::*;
#(
  parameter int unsigned WIDTH = LIST_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      ready,
  output logic                      src_req,
  input  logic                      src_ack,
  input  logic [WIDTH-1:0]          src_value,
  input  logic                      src_value_valid,
  input  logic                      req,
  output logic                      ack,
  output logic [WIDTH-1:0]          value,
  output logic                      value_valid,
  output logic [fill_w(DEPTH)-1:0]  fill
);

  localparam int unsigned FW = fill_w(DEPTH);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic             ended_q, ended_d;
  logic             ack_q;
  logic [WIDTH-1:0] value_q, value_d;
  logic             vv_q;
  logic             push, pop, serve;
  logic [WIDTH-1:0] head;
  logic [FW-1:0]    fill_w_s;

  list_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .ready (ready),
    .push  (push),
    .din   (src_value),
    .pop   (pop),
    .head  (head),
    .fill  (fill_w_s)
  );

  assign src_req = ready & ~ended_q & (fill_w_s < FULL);

  // buffered data drains before the terminator is replayed
  always_comb begin
    push    = src_req & src_ack & (src_value_valid != LIST_END);
    ended_d = ended_q | (src_req & src_ack & (src_value_valid == LIST_END));
    pop     = req & (fill_w_s != '0);
    serve   = pop | (req & ended_q);
    value_d = pop ? head : value_q;
  end

  always_ff @(posedge clock or negedge ready) begin
    if (!ready) begin
      ended_q <= 1'b0;
      ack_q   <= 1'b0;
      value_q <= '0;
      vv_q    <= LIST_END;
    end else begin
      ended_q <= ended_d;
      ack_q   <= serve;
      value_q <= value_d;
      vv_q    <= pop ? ~LIST_END : LIST_END;
    end
  end

  assign ack         = ack_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign fill        = fill_w_s;

endmodule

// File: tb/tb_list_prefetch.sv
// Scoreboard bench for list_prefetch: directed upstream/consumer
// sequences with a negedge monitor checking every ack.
module tb_list_prefetch;

  logic       clock = 1'b0;
  logic       ready = 1'b0;
  logic       src_req;
  logic       src_ack = 1'b0;
  logic [7:0] src_value = '0;
  logic       src_value_valid = 1'b0;
  logic       req = 1'b0;
  logic       ack;
  logic [7:0] value;
  logic       value_valid;
  logic [2:0] fill;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;
  logic [8:0] sb_q[$];
  logic [7:0] last_val = '0;

  list_prefetch #(.WIDTH(8), .DEPTH(4)) dut (
    .clock           (clock),
    .ready           (ready),
    .src_req         (src_req),
    .src_ack         (src_ack),
    .src_value       (src_value),
    .src_value_valid (src_value_valid),
    .req             (req),
    .ack             (ack),
    .value           (value),
    .value_valid     (value_valid),
    .fill            (fill)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic exp_el(input logic [7:0] v);
    sb_q.push_back({1'b1, v});
    last_val = v;
  endtask

  task automatic exp_end;
    sb_q.push_back({1'b0, last_val});
  endtask

  task automatic up_send(input logic vld, input logic [7:0] v);
    int n = 0;
    while (!src_req && n < 50) begin
      tick;
      n++;
    end
    chk("src_req_timeout", int'(src_req), 1);
    src_ack         = 1'b1;
    src_value       = v;
    src_value_valid = vld;
    tick;
    src_ack         = 1'b0;
    src_value_valid = 1'b0;
  endtask

  task automatic rst_pulse;
    ready = 1'b0;
    #1;
    chk("rst_fill", int'(fill), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_src_req", int'(src_req), 0);
    tick;
    ready = 1'b1;
    last_val = '0;
    #1;
    chk("rel_src_req", int'(src_req), 1);
  endtask

  task automatic hold_req(input int n);
    req = 1'b1;
    repeat (n) tick;
    req = 1'b0;
  endtask

  // monitor: every ack must match the head of the scoreboard
  always @(negedge clock) begin
    if (ready && ack) begin
      ack_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: value %0h valid %0b", value, value_valid);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("ack_valid", int'(value_valid), int'(e[8]));
        chk("ack_value", int'(value), int'(e[7:0]));
      end
    end
  end

  initial begin
    int base;
    // reset with random inputs
    repeat (4) begin
      req             = 1'($urandom);
      src_ack         = 1'($urandom);
      src_value       = 8'($urandom);
      src_value_valid = 1'($urandom);
      @(negedge clock);
      chk("rsthold_ack", int'(ack), 0);
      chk("rsthold_vv", int'(value_valid), 0);
      chk("rsthold_value", int'(value), 0);
      chk("rsthold_fill", int'(fill), 0);
      chk("rsthold_src_req", int'(src_req), 0);
    end
    @(posedge clock);
    #1;
    req = 0; src_ack = 0; src_value = 0; src_value_valid = 0;
    ready = 1'b1;
    #1;
    chk("first_src_req", int'(src_req), 1);
    tick;

    // short list 3,7,9,end
    up_send(1'b1, 8'd3);
    up_send(1'b1, 8'd7);
    up_send(1'b1, 8'd9);
    up_send(1'b0, 8'd0);
    chk("short_fill", int'(fill), 3);
    chk("short_src_req", int'(src_req), 0);
    exp_el(8'd3); exp_el(8'd7); exp_el(8'd9); exp_end; exp_end;
    hold_req(5);
    tick; tick;
    chk("short_drained", int'(fill), 0);
    rst_pulse;
    tick;

    // fill to DEPTH
    for (int i = 1; i <= 4; i++) up_send(1'b1, 8'(i));
    chk("full_fill", int'(fill), 4);
    chk("full_src_req", int'(src_req), 0);
    exp_el(8'd1);
    hold_req(1);
    chk("pop_fill", int'(fill), 3);
    chk("pop_src_req", int'(src_req), 1);
    up_send(1'b1, 8'd5);
    chk("refill_fill", int'(fill), 4);
    chk("refill_src_req", int'(src_req), 0);
    exp_el(8'd2); exp_el(8'd3); exp_el(8'd4); exp_el(8'd5);
    hold_req(4);
    tick; tick;
    rst_pulse;
    tick;

    // empty stall
    exp_el(8'h55);
    base = ack_cnt;
    req = 1'b1;
    tick; tick; tick;
    chk("stall_no_ack", ack_cnt, base);
    src_ack = 1'b1; src_value = 8'h55; src_value_valid = 1'b1;
    tick;
    src_ack = 1'b0; src_value_valid = 1'b0;
    @(negedge clock);
    chk("stall_ack_t1", int'(ack), 0);
    @(posedge clock);
    #1;
    req = 1'b0;
    @(negedge clock);
    chk("stall_ack_t2", int'(ack), 1);
    tick;
    tick;

    // streaming push+pop at fill=2 across pointer wrap
    up_send(1'b1, 8'd10);
    up_send(1'b1, 8'd11);
    chk("stream_pre_fill", int'(fill), 2);
    for (int i = 0; i < 10; i++) begin
      exp_el(8'(10 + i));
      src_ack = 1'b1; src_value = 8'(12 + i); src_value_valid = 1'b1;
      req = 1'b1;
      tick;
      chk("stream_fill", int'(fill), 2);
    end
    src_ack = 1'b0; src_value_valid = 1'b0; req = 1'b0;
    exp_el(8'd20); exp_el(8'd21);
    hold_req(2);
    tick; tick;
    chk("stream_drained", int'(fill), 0);

    // mid-stream reset with ended set and a request in flight
    up_send(1'b1, 8'hA1);
    up_send(1'b1, 8'hA2);
    up_send(1'b1, 8'hA3);
    up_send(1'b0, 8'h00);
    chk("mid_fill", int'(fill), 3);
    base = ack_cnt;
    req = 1'b1;
    #1;
    ready = 1'b0;
    #1;
    chk("mid_rst_fill", int'(fill), 0);
    chk("mid_rst_ack", int'(ack), 0);
    tick; tick;
    req = 1'b0;
    chk("mid_no_ack", ack_cnt, base);
    ready = 1'b1;
    last_val = '0;
    #1;
    chk("mid_restart_src_req", int'(src_req), 1);
    tick;
    up_send(1'b1, 8'h42);
    up_send(1'b0, 8'h00);
    exp_el(8'h42); exp_end;
    hold_req(2);
    tick; tick; tick;

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1);
  end

endmodule
